dsa_stream_loader: RTL and testbench

//  Avalon-MM master that sits directly upstream of the DSA Avalon-MM slave.
//  - Takes an 8-bit pixel stream and packs it into 32-bit words.
//  - Writes the words into the DSA input window, writes the start register,

---
 rtl/dsa_stream_loader.sv | 227 ++++++++++++++++++++++
 tb/tb_dsa_stream_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsa_stream_loader.sv
// Stream-to-DSA loader: packs bytes into words, writes the DSA window,
// starts the DSA and polls status. Optional poll timeout: DSA_LOADER_TIMEOUT_EN.
module dsa_stream_loader #(
    parameter int                    ADDR_WIDTH    = 16,
    parameter int                    LEN_WIDTH     = 18,
    parameter logic [ADDR_WIDTH-1:0] IN_WIN_BASE   = 16'h1000,
    parameter logic [ADDR_WIDTH-1:0] CTRL_ADDR     = 16'h0000,
    parameter logic [ADDR_WIDTH-1:0] STATUS_ADDR   = 16'h0001,
    parameter int                    DONE_BIT      = 1,
    parameter int                    POLL_GAP      = 4,
    parameter int                    TIMEOUT_POLLS = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_start,
    input  logic [LEN_WIDTH-1:0]  cfg_len,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    output logic                  avm_write,
    output logic [3:0]            avm_byteenable,
    output logic [31:0]           avm_writedata,
    input  logic [31:0]           avm_readdata,
    input  logic                  avm_waitrequest,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int GW = $clog2(POLL_GAP + 1);

    typedef enum logic [2:0] {
        IDLE,
        PACK,
        WR_DATA,
        WR_START,
        POLL_RD,
        POLL_WAIT,
        GAP,
        DONE
    } state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  left;
    logic [1:0]            byte_idx;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [31:0]           pack;
    logic [GW-1:0]         gap_cnt;

    logic [31:0] next_pack;
    logic [3:0]  last_be;
    logic        take;
    logic        word_end;
    logic        unused_bits;

`ifdef DSA_LOADER_TIMEOUT_EN
    localparam int PW = $clog2(TIMEOUT_POLLS + 1);
    logic [PW-1:0] poll_cnt;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_POLLS == 0);
    assign err = 1'b0;
`endif

    assign unused_bits = ^avm_readdata;
    assign take        = s_valid && s_ready;
    assign word_end    = (byte_idx == 2'd3) || (left == LEN_WIDTH'(1));

    // Incoming byte lands in its little-endian lane of the word being built.
    always_comb begin
        next_pack = pack;
        last_be   = 4'b0001;
        case (byte_idx)
            2'd0: begin
                next_pack[7:0] = s_data;
                last_be        = 4'b0001;
            end
            2'd1: begin
                next_pack[15:8] = s_data;
                last_be         = 4'b0011;
            end
            2'd2: begin
                next_pack[23:16] = s_data;
                last_be          = 4'b0111;
            end
            default: begin
                next_pack[31:24] = s_data;
                last_be          = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            left           <= '0;
            byte_idx       <= '0;
            word_idx       <= '0;
            pack           <= '0;
            gap_cnt        <= '0;
            s_ready        <= 1'b0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef DSA_LOADER_TIMEOUT_EN
            poll_cnt       <= '0;
            err            <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_start) begin
                        left     <= cfg_len;
                        byte_idx <= '0;
                        word_idx <= '0;
                        pack     <= '0;
`ifdef DSA_LOADER_TIMEOUT_EN
                        poll_cnt <= '0;
                        err      <= 1'b0;
`endif
                        if (cfg_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= PACK;
                            busy    <= 1'b1;
                            s_ready <= 1'b1;
                        end
                    end
                end
                PACK: begin
                    if (take) begin
                        left <= left - LEN_WIDTH'(1);
                        if (word_end) begin
                            state          <= WR_DATA;
                            s_ready        <= 1'b0;
                            avm_write      <= 1'b1;
                            avm_address    <= IN_WIN_BASE + word_idx;
                            avm_writedata  <= next_pack;
                            avm_byteenable <= last_be;
                            byte_idx       <= '0;
                            pack           <= '0;
                        end else begin
                            pack     <= next_pack;
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                WR_DATA: begin
                    if (!avm_waitrequest) begin
                        word_idx <= word_idx + ADDR_WIDTH'(1);
                        if (left == '0) begin
                            // Start write follows back-to-back on the bus.
                            state          <= WR_START;
                            avm_address    <= CTRL_ADDR;
                            avm_writedata  <= 32'h1;
                            avm_byteenable <= 4'hF;
                        end else begin
                            state     <= PACK;
                            avm_write <= 1'b0;
                            s_ready   <= 1'b1;
                        end
                    end
                end
                WR_START: begin
                    if (!avm_waitrequest) begin
                        state          <= POLL_RD;
                        avm_write      <= 1'b0;
                        avm_read       <= 1'b1;
                        avm_address    <= STATUS_ADDR;
                        avm_writedata  <= '0;
                        avm_byteenable <= 4'hF;
                    end
                end
                POLL_RD: begin
                    if (!avm_waitrequest) begin
                        state    <= POLL_WAIT;
                        avm_read <= 1'b0;
`ifdef DSA_LOADER_TIMEOUT_EN
                        poll_cnt <= poll_cnt + PW'(1);
`endif
                    end
                end
                POLL_WAIT: begin
                    if (avm_readdata[DONE_BIT]) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
`ifdef DSA_LOADER_TIMEOUT_EN
                    end else if (poll_cnt >= PW'(TIMEOUT_POLLS)) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        err   <= 1'b1;
`endif
                    end else begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GW'(POLL_GAP - 1)) begin
                        state       <= POLL_RD;
                        avm_read    <= 1'b1;
                        avm_address <= STATUS_ADDR;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dsa_stream_loader.sv
// Bench for dsa_stream_loader: vector table, corner sequences and
// randomized jobs against a word-level model and a stalling slave.
module tb_dsa_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [17:0] cfg_len;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [15:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    dsa_stream_loader #(.TIMEOUT_POLLS(3)) dut (
        .clk(clk), .reset(reset),
        .cfg_start(cfg_start), .cfg_len(cfg_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_write(avm_write), .avm_byteenable(avm_byteenable),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        int          len;
        int          ws;
        int          polls;
        logic [7:0]  b0;
        logic [7:0]  step;
        int          exp_dw;
        logic [31:0] exp_w0;
        logic [31:0] exp_wl;
        logic [3:0]  exp_lbe;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] src[$];
    wr_t        wq[$];
    int acc_cnt, wr_cyc, rd_cyc, rd_acc, done_cnt;
    int wait_cfg, done_after, polls_seen, wcnt;
    int cyc_no, last_rd;
    bit stall_prev, rd_prev;
    logic [15:0] p_a;
    logic [31:0] p_d;
    logic [3:0]  p_be;
    logic        p_r, p_w;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave: each request stalls wait_cfg cycles; status done after N reads.
    assign avm_waitrequest = (avm_read || avm_write) && (wcnt < wait_cfg);

    always @(posedge clk) begin
        logic [31:0] rd;
        if (reset) begin
            wcnt <= 0;
        end else if (avm_read || avm_write) begin
            if (!avm_waitrequest) wcnt <= 0;
            else wcnt <= wcnt + 1;
        end
        if (!reset && avm_read && !avm_waitrequest) begin
            rd = $urandom;
            rd[1] = (polls_seen + 1 >= done_after);
            avm_readdata <= rd;
            polls_seen <= polls_seen + 1;
        end
    end

    // Mid-cycle monitor: handshakes, bus stability, overlap, poll spacing.
    always @(negedge clk) begin
        cyc_no++;
        if (!reset) begin
            if (s_valid && s_ready) acc_cnt++;
            if (avm_write) wr_cyc++;
            if (avm_read) rd_cyc++;
            if (done) done_cnt++;
            if (avm_read || avm_write)
                chk("rd_wr_overlap", {avm_read, avm_write} == 2'b11, 0);
            if (avm_read && !rd_prev && last_rd >= 0)
                chk("poll_spacing", cyc_no - last_rd, 6);
            if (avm_write && !avm_waitrequest)
                wq.push_back('{avm_address, avm_writedata, avm_byteenable});
            if (avm_read && !avm_waitrequest) begin
                rd_acc++;
                last_rd = cyc_no;
            end
            if (stall_prev)
                chk("stall_hold", {avm_read, avm_write, avm_address,
                                   avm_writedata, avm_byteenable},
                    {p_r, p_w, p_a, p_d, p_be});
        end
        stall_prev = !reset && (avm_read || avm_write) && avm_waitrequest;
        rd_prev = avm_read;
        p_r = avm_read; p_w = avm_write; p_a = avm_address;
        p_d = avm_writedata; p_be = avm_byteenable;
    end

    function automatic wr_t model_word(input int k, input int len);
        wr_t w;
        w.a  = 16'h1000 + 16'(k);
        w.d  = '0;
        w.be = '0;
        for (int i = 0; i < 4; i++) begin
            if (4 * k + i < len) begin
                w.d  = w.d | (32'(src[4 * k + i]) << (8 * i));
                w.be = w.be | 4'(1 << i);
            end
        end
        return w;
    endfunction

    task automatic run_job(input int len, input int ws, input int polls,
                           input bit rnd, input bit poke, input bit tmo);
        int  off = 0;
        int  cyc = 0;
        int  nw  = (len + 3) / 4;
        bit  hs;
        wq.delete();
        acc_cnt = 0; rd_acc = 0; done_cnt = 0; last_rd = -1;
        wait_cfg = ws;
        done_after = tmo ? 32'h7fffffff : polls;
        polls_seen = 0;
        @(posedge clk); #1;
        cfg_len = 18'(len);
        cfg_start = 1'b1;
        s_valid = 1'b0;
        while (done_cnt == 0 && cyc < 4000) begin
            hs = s_valid && s_ready;
            @(posedge clk); #1;
            if (hs) off++;
            cfg_start = 1'b0;
            if (cyc == 0) cfg_len = 18'($urandom);
            if (poke && cyc == 2) cfg_start = 1'b1;
            s_valid = (off < src.size()) && (!rnd || $urandom_range(3) != 0);
            s_data = (off < src.size()) ? src[off] : 8'h00;
            cyc++;
        end
        s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("job_timeout", cyc < 4000, 1);
        chk("bytes_accepted", acc_cnt, len);
        chk("done_pulses", done_cnt, 1);
        chk("busy_after", busy, 0);
        chk("err_after", err, tmo);
        chk("status_reads", rd_acc, tmo ? 3 : polls);
        chk("write_count", wq.size(), nw + 1);
        for (int k = 0; k < nw && k < wq.size(); k++) begin
            wr_t m = model_word(k, len);
            chk("data_write", {wq[k].a, wq[k].d, wq[k].be}, {m.a, m.d, m.be});
        end
        if (wq.size() == nw + 1)
            chk("start_write", {wq[nw].a, wq[nw].d, wq[nw].be},
                {16'h0000, 32'h1, 4'hF});
    endtask

    task automatic fill_src(input int len, input logic [7:0] b0,
                            input logic [7:0] step, input bit rnd);
        logic [7:0] b = b0;
        src.delete();
        for (int i = 0; i < len + 3; i++) begin
            src.push_back(rnd ? 8'($urandom) : b);
            b = b + step;
        end
    endtask

    vec_t vt[8];

    initial begin
        int w0, r0, n, spin;
        vt[0] = '{8, 0, 1, 8'h01, 8'h01, 2, 32'h04030201, 32'h08070605, 4'hF};
        vt[1] = '{5, 0, 2, 8'hAA, 8'h11, 2, 32'hDDCCBBAA, 32'h000000EE, 4'h1};
        vt[2] = '{9, 3, 2, 8'h10, 8'h01, 3, 32'h13121110, 32'h00000018, 4'h1};
        vt[3] = '{1, 0, 1, 8'h5A, 8'h01, 1, 32'h0000005A, 32'h0000005A, 4'h1};
        vt[4] = '{2, 1, 3, 8'hF0, 8'h01, 1, 32'h0000F1F0, 32'h0000F1F0, 4'h3};
        vt[5] = '{3, 2, 1, 8'h21, 8'h02, 1, 32'h00252321, 32'h00252321, 4'h7};
        vt[6] = '{4, 0, 1, 8'h80, 8'h01, 1, 32'h83828180, 32'h83828180, 4'hF};
        vt[7] = '{7, 1, 2, 8'h01, 8'h10, 2, 32'h31211101, 32'h00615141, 4'h7};

        reset = 1'b1; cfg_start = 1'b0; cfg_len = '0;
        s_valid = 1'b0; s_data = '0; avm_readdata = '0;
        wait_cfg = 0; done_after = 1; polls_seen = 0; wcnt = 0;
        cyc_no = 0; last_rd = -1; stall_prev = 0; rd_prev = 0;
        acc_cnt = 0; wr_cyc = 0; rd_cyc = 0; rd_acc = 0; done_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {s_ready, avm_address, avm_read, avm_write,
                              avm_byteenable, avm_writedata, busy, done, err}, 0);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            fill_src(vt[v].len, vt[v].b0, vt[v].step, 0);
            run_job(vt[v].len, vt[v].ws, vt[v].polls, 0, 0, 0);
            n = wq.size();
            chk("vec_data_writes", n - 1, vt[v].exp_dw);
            if (n > 1) begin
                chk("vec_word0", wq[0].d, vt[v].exp_w0);
                chk("vec_last_word", wq[n - 2].d, vt[v].exp_wl);
                chk("vec_last_be", wq[n - 2].be, vt[v].exp_lbe);
                chk("vec_word0_addr", wq[0].a, 16'h1000);
            end
        end

        // Zero-length job: done seen on the second edge, no bus traffic.
        w0 = wr_cyc; r0 = rd_cyc;
        @(posedge clk); #1;
        cfg_len = '0; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        chk("len0_done_high", done, 1);
        chk("len0_busy", busy, 0);
        @(posedge clk); #1;
        chk("len0_done_low", done, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("len0_bus_cycles", {wr_cyc - w0, rd_cyc - r0}, 0);

        // Reset while the first data write is stalled.
        fill_src(8, 8'h40, 8'h01, 0);
        wait_cfg = 5; done_after = 1; polls_seen = 0;
        @(posedge clk); #1;
        cfg_len = 18'd8; cfg_start = 1'b1; s_valid = 1'b1; s_data = 8'h55;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        spin = 0;
        while (!avm_write && spin < 100) begin
            @(posedge clk); #1;
            spin++;
        end
        chk("rst_reached_write", {avm_write, avm_waitrequest}, 2'b11);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_job", {s_ready, avm_address, avm_read, avm_write,
                            avm_byteenable, avm_writedata, busy, done, err}, 0);
        reset = 1'b0; s_valid = 1'b0;
        fill_src(4, 8'h61, 8'h01, 0);
        run_job(4, 0, 1, 0, 0, 0);

`ifdef DSA_LOADER_TIMEOUT_EN
        fill_src(4, 8'h01, 8'h01, 0);
        run_job(4, 0, 3, 0, 0, 1);
        @(posedge clk); #1;
        cfg_len = '0; cfg_start = 1'b1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        chk("err_cleared", err, 0);
        repeat (3) @(posedge clk);
`endif

        for (int j = 0; j < 12; j++) begin
            int len = $urandom_range(40, 1);
            fill_src(len, 8'h00, 8'h00, 1);
            run_job(len, $urandom_range(3), $urandom_range(3, 1), 1, 1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
